// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32M funct3 encodings; bit 2 separates divides from multiplies.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Divide-by-zero quotient and the most negative integer (signed overflow case).
  localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN_DEFAULT-1:0] INT_MIN    = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: iterative datapath. Holds the multiplicand/divisor and the
// {hi, lo} accumulator pair; each step is one shift-add (multiply) or one
// restoring shift-subtract (divide). Multiply ends with the product in
// {hi, lo}; divide ends with remainder in hi and quotient in lo.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] op_a_i,     // multiplicand or divisor magnitude
  input  logic [XLEN-1:0] op_b_i,     // multiplier or dividend magnitude
  output logic [XLEN-1:0] step_hi_o,  // accumulator values after the current step
  output logic [XLEN-1:0] step_lo_o
);

  logic [XLEN-1:0] a_q, hi_q, lo_q;
  logic [XLEN-1:0] a_d, hi_d, lo_d;
  logic [XLEN-1:0] hi_step, lo_step;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    // Multiply: conditionally add multiplicand to hi, then shift {carry, hi, lo} right.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    // Divide: shift next dividend bit into the partial remainder, subtract if it fits.
    // The difference is below the divisor whenever it is kept, so XLEN bits suffice.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, a_q});
    div_diff  = div_shift[XLEN-1:0] - a_q;
    if (is_div_i) begin
      hi_step = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Register next-state select: load fresh operands, step, or hold.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the leading defaults); a missing path infers a latch.
  always_comb begin
    a_d  = a_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      a_d  = op_a_i;
      hi_d = '0;
      lo_d = op_b_i;
    end else if (step_i) begin
      hi_d = hi_step;
      lo_d = lo_step;
    end
  end

  // Operand and accumulator registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      a_q  <= a_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign step_hi_o = hi_step;
  assign step_lo_o = lo_step;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide controller for the EX stage.
// IDLE -> BUSY (XLEN iterations) -> DONE, with divide-by-zero and signed
// overflow resolved directly from IDLE. Define FAST_MUL_EN to compute all
// multiplies in a single cycle (IDLE -> DONE); divides always iterate.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            STALL,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign1_q, sign1_d, sign2_q, sign2_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              core_load, core_step;
  logic [XLEN-1:0]   step_hi, step_lo;

  logic              is_div, rs1_signed, rs2_signed;
  logic              in_sign1, in_sign2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, core_a, core_b;

  // Applies the recorded operand signs to a raw magnitude result and picks
  // the half/field the instruction returns.
  function automatic logic [XLEN-1:0] fix_sign(input logic [2:0]      f3,
                                               input logic            s1,
                                               input logic            s2,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    prod = {hi, lo};
    if (s1 ^ s2) prod = -prod;
    case (f3)
      F3_MUL:                       res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res = prod[2*XLEN-1:XLEN];
      F3_DIV:                       res = (s1 ^ s2) ? -lo : lo;
      F3_DIVU:                      res = lo;
      F3_REM:                       res = s1 ? -hi : hi;
      default:                      res = hi;
    endcase
    return res;
  endfunction

  // Decode the incoming instruction: signedness, magnitudes, special cases.
  always_comb begin
    is_div     = FUNCT3[2];
    rs1_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
                 (FUNCT3 == F3_DIV)  || (FUNCT3 == F3_REM);
    rs2_signed = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    in_sign1   = rs1_signed && OPERAND1[XLEN-1];
    in_sign2   = rs2_signed && OPERAND2[XLEN-1];
    mag1       = in_sign1 ? -OPERAND1 : OPERAND1;
    mag2       = in_sign2 ? -OPERAND2 : OPERAND2;
    core_a     = is_div ? mag2 : mag1;
    core_b     = is_div ? mag1 : mag2;
    div_zero   = is_div && (OPERAND2 == '0);
    div_ovf    = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                 (OPERAND1 == INT_MIN) && (OPERAND2 == '1);
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] prod_fast;
  assign prod_fast = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  // FSM next-state, counter, and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          funct3_d  = FUNCT3;
          sign1_d   = in_sign1;
          sign2_d   = in_sign2;
          core_load = 1'b1;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = FUNCT3[1] ? OPERAND1 : DIV_ZERO_Q;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = FUNCT3[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end
`ifdef FAST_MUL_EN
          else if (!is_div) begin
            result_d = fix_sign(FUNCT3, in_sign1, in_sign2,
                                prod_fast[2*XLEN-1:XLEN], prod_fast[XLEN-1:0]);
            state_d  = S_DONE;
          end
`endif
          else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d    = '0;
          result_d = fix_sign(funct3_q, sign1_q, sign2_q, step_hi, step_lo);
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over everything: abandon the operation, keep the old result.
    if (FLUSH) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      result_d  = result_q;
      core_load = 1'b0;
      core_step = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_i    (core_load),
    .step_i    (core_step),
    .is_div_i  (funct3_q[2]),
    .op_a_i    (core_a),
    .op_b_i    (core_b),
    .step_hi_o (step_hi),
    .step_lo_o (step_lo)
  );

  assign BUSY   = (state_q == S_BUSY);
  assign VALID  = (state_q == S_DONE) && !FLUSH;
  assign STALL  = START && !VALID && !FLUSH;
  assign RESULT = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, sitting in the EX stage beside the ALU.
- Accepts one operation from ID/EX, runs an iterative shift-add multiply or restoring divide, and raises STALL to the hazard unit until the result is valid.
- Resolves RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  level request; EX holds it high with stable operands until VALID
- FUNCT3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- OPERAND1  in  XLEN  rs1 value
- OPERAND2  in  XLEN  rs2 value
- FLUSH  in  1  synchronous abort (branch/jump flush of EX)
- BUSY  out  1  high in BUSY state
- STALL  out  1  combinational: START & ~VALID & ~FLUSH
- VALID  out  1  one-cycle result strobe
- RESULT  out  XLEN  result, held until next accept

Behaviour:
- Async RESET: state=IDLE, BUSY=0, VALID=0, RESULT=0, counter=0, operand registers=0.
- States:
  - IDLE: if START & ~FLUSH, latch FUNCT3 and operands, then go to BUSY; special case or fast path goes straight to DONE.
  - BUSY: one iteration per cycle; counter runs 0..XLEN-1; at XLEN-1 go to DONE.
  - DONE: VALID=1, RESULT driven; next state IDLE unconditionally.
- Latency: START first seen in IDLE at cycle 0; VALID in cycle XLEN+1 (33). Special cases and fast path give VALID in cycle 1.
- Back-to-back: START still high in the cycle after DONE is a new instruction; it is accepted from IDLE. Minimum spacing is 2 cycles.
- Multiply:
  - Signed operands converted to magnitude per funct3: MULH both signed, MULHSU rs1 only, MULHU/MUL none.
  - 2*XLEN product accumulated, then negated if the signs differ.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide:
  - Magnitudes are used for DIV/REM.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = dividend sign.
- Special cases (latched in IDLE, go to DONE):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return OPERAND1.
  - DIV with OPERAND1=0x80000000 and OPERAND2=0xFFFFFFFF: result 0x80000000; REM gives 0.
- FLUSH in any state: next state IDLE, VALID forced 0, RESULT unchanged. FLUSH beats START in the same cycle.
- START dropping while BUSY (not expected): the operation completes and VALID pulses; the result is ignored upstream.
- RESET mid-operation: immediate return to the reset values above.

Optional Feature:
- FAST_MUL_EN defined: MUL* ops computed with a single-cycle XLEN×XLEN multiply, IDLE→DONE, VALID in cycle 1. Divides are unchanged.
- Undefined: all multiplies iterate XLEN cycles, as above.

Decomposition:
- muldiv_pkg: funct3 localparams (F3_MUL … F3_REMU), state encoding (IDLE/BUSY/DONE), XLEN default, special-case constants (DIV_ZERO_Q, INT_MIN).
- One sub-module, muldiv_core: accumulator/quotient/remainder registers and the per-iteration shift-add/subtract step. muldiv_sequencer holds the FSM, counter, sign fix-up and special-case detection.

Test Plan:
- MUL 7×(-3) (0x00000007, 0xFFFFFFFD), START held → STALL high for 33 cycles, VALID in cycle 33, RESULT=0xFFFFFFEB; with FAST_MUL_EN, VALID in cycle 1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → RESULT=0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → RESULT=0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; all with VALID at cycle 33.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; each with VALID at cycle 1.
- FLUSH at BUSY cycle 10 → IDLE next cycle, no VALID pulse; FLUSH and START in the same IDLE cycle → no accept.
- RESET asserted asynchronously mid-BUSY → BUSY/VALID/RESULT=0 immediately; after release, DIVU 9/3 completes with RESULT=3.
